dm_box_blur_stream: RTL and testbench
=====================================

// Module: dm_box_blur_stream
// PURPOSE
//  Parametrised KxK box-blur (mean) filter for the Avalon-ST RGB video path. It uses K-1 line buffers
//  and a KxK window register, zero-pads outside frame edges, and is a fully backpressure-aware stream stage.
//  The output frame has the same size and framing as the input. Blur is enabled per frame;
//  with blur off the stage passes pixels through at identical latency.
//  Sits between the camera/pixel source and the VGA/output stage, in the same slot as the fixed 5x5 blur.
// PARAMETERS
//  IMG_W     320  pixels per line (>= K)
//  IMG_H     240  lines per frame (>= K)
//  BPC       4    bits per colour channel
//  CHANNELS  3    channels packed MSB-first in data (R,G,B)
//  K         5    kernel width; odd, 3..7; H = K/2
//  RECIP     round(65536/(K*K))  Q0.16 reciprocal; 2621 for K=5, 7282 for K=3
// PORTS
//  clk                input   1             single clock, all logic posedge
//  reset              input   1             synchronous, active-high
//  data_in            input   CHANNELS*BPC  input pixel
//  valid_in           input   1             upstream valid
//  ready_out          output  1             to upstream: beat accepted when valid_in & ready_out
//  startofpacket_in   input   1             first pixel of frame
//  endofpacket_in     input   1             last pixel of frame (checked, not used for framing)
//  blur_en            input   1             sampled on accepted SOP beat; 0 = bypass for that frame
//  data_out           output  CHANNELS*BPC  output pixel
//  valid_out          output  1             output valid
//  ready_in           input   1             from downstream
//  startofpacket_out  output  1             with output pixel (0,0)
//  endofpacket_out    output  1             with output pixel (IMG_W-1,IMG_H-1)
//  len_err            output  1             one-cycle pulse on endofpacket_in framing mismatch
// BEHAVIOUR
//  Reset: state=IDLE; valid_out, startofpacket_out, endofpacket_out, len_err=0; data_out=0; counters=0.
//    ready_out=0 while reset=1. Line-buffer contents are not cleared; edge masks make them irrelevant.
//  Pipeline advance: adv = !valid_out | ready_in. ready_out = adv & (state!=FLUSH). No accept when !adv.
//  States:
//    IDLE:  ready_out=1 (when adv). Non-SOP beats are dropped. An accepted SOP beat latches blur_en,
//           stores pixel idx 0, and goes to FILL.
//    FILL:  accept pixels, no output, until accepted idx = H*IMG_W+H (window centre (0,0) complete), then RUN.
//    RUN:   each accepted pixel idx i loads one output for centre idx i-(H*IMG_W+H) into the output register
//           on the same edge. After the accepted pixel IMG_W*IMG_H-1, go to FLUSH.
//    FLUSH: ready_out=0. The stage generates H*IMG_W+H virtual zero pixels, one per adv cycle, each
//           producing the next output. After the output with endofpacket_out is loaded, go to IDLE.
//  Latency: 1 clk from the enabling accept (or flush step) to valid_out. Exactly IMG_W*IMG_H outputs per frame.
//  Window: taps with row<0, row>=IMG_H, col<0 or col>=IMG_W read as 0 (no wrap across line edges).
//  Arithmetic, per channel: sum is unsigned, width BPC+$clog2(K*K).
//    mean = (sum*RECIP + 32768) >> 16, saturated to 2^BPC-1.
//    Divisor is always K*K, including at the edges (edges darken).
//  Bypass (latched blur_en=0): data_out = window centre tap; framing and latency unchanged.
//  startofpacket_out=1 only with output idx 0; endofpacket_out=1 only with output idx IMG_W*IMG_H-1.
//  len_err: pulses 1 clk if endofpacket_in is accepted at idx != IMG_W*IMG_H-1, or if the pixel at that idx
//    lacks endofpacket_in. Framing continues by count.
//  SOP accepted in FILL/RUN: abort the current frame. Remaining outputs are dropped (no EOP for it).
//    An already-registered valid_out beat completes normally. Restart at idx 0 with blur_en re-latched.
//  SOP seen in FLUSH: not accepted (ready_out=0); it is taken after returning to IDLE.
//  Backpressure: data_out and flags stay stable while valid_out & !ready_in. No beat is lost or duplicated.
//  Reset mid-frame: immediate return to IDLE. The next frame is processed correctly from its SOP.
// TESTING  (bench uses IMG_W=8, IMG_H=6, K=3 unless noted)
//  1. Constant frame 0xFFF, blur_en=1, ready_in=1 -> interior outputs 0xFFF; corner (0,0) 4/9*15 -> 0x777;
//     top edge 6/9*15 -> 0xAAA. 48 outputs, SOP on the 1st, EOP on the 48th.
//  2. Same frame with blur_en=0 -> output equals input pixel-for-pixel; first valid_out 1 clk after accept #10.
//  3. Single 0xF00 impulse at (3,3) on black, K=5 default size -> 25 outputs 0x100 (15*2621 rounds to 1),
//     rest 0x000.
//  4. Random ready_in (50%) and valid_in (70%) gaps -> output sequence identical to no-stall run;
//     data_out stable while stalled.
//  5. SOP re-issued at idx 20, then full frame -> no EOP for the aborted frame; next frame has 48 clean outputs.
//  6. endofpacket_in on idx 40 -> len_err pulses once; frame still ends at output 48. Reset at idx 30
//     then new frame -> correct output.

Source files
------------

// File: rtl/dm_box_blur_stream.sv
// rtl/dm_box_blur_stream.sv - KxK box-blur stream stage with zero-padded edges and per-frame bypass
module dm_box_blur_stream #(
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 240,
    parameter int BPC      = 4,
    parameter int CHANNELS = 3,
    parameter int K        = 5,
    parameter int RECIP    = (2 * 65536 + K * K) / (2 * K * K)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CHANNELS*BPC-1:0] data_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic                    startofpacket_in,
    input  logic                    endofpacket_in,
    input  logic                    blur_en,
    output logic [CHANNELS*BPC-1:0] data_out,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic                    startofpacket_out,
    output logic                    endofpacket_out,
    output logic                    len_err
);

    localparam int DW   = CHANNELS * BPC;
    localparam int H    = K / 2;
    localparam int NPIX = IMG_W * IMG_H;
    localparam int DLY  = H * IMG_W + H;
    localparam int IW   = $clog2(NPIX + 1);
    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int SW   = BPC + $clog2(K * K);
    localparam int PW   = SW + 18;

    localparam logic [IW-1:0] IDX_LAST = IW'(NPIX - 1);
    localparam logic [IW-1:0] IDX_DLY  = IW'(DLY);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

    state_t          state_q;
    logic            blur_q;
    logic [CW-1:0]   in_col_q;
    logic [IW-1:0]   in_idx_q;
    logic [RW-1:0]   cen_row_q;
    logic [CW-1:0]   cen_col_q;
    logic [IW-1:0]   cen_idx_q;
    logic [DW-1:0]   data_out_q;
    logic            valid_out_q;
    logic            sop_out_q;
    logic            eop_out_q;
    logic            len_err_q;

    // lb_q[j][col] holds the pixel j+1 rows above the newest one at that column
    logic [DW-1:0]   lb_q  [K-1][IMG_W];
    logic [DW-1:0]   win_q [K][K];
    logic [DW-1:0]   win_d [K][K];

    logic            adv;
    logic            accept;
    logic            start;
    logic            acc_run;
    logic            flush_step;
    logic            push;
    logic            emit;
    logic [DW-1:0]   push_pix;
    logic [CW-1:0]   push_col;
    logic [IW-1:0]   cur_idx;
    logic            len_err_d;
    logic [K-1:0]    row_ok;
    logic [K-1:0]    col_ok;
    logic [SW-1:0]   sum_c;
    logic [PW-1:0]   prod;
    logic [DW-1:0]   blur_pix;
    logic [DW-1:0]   data_d;

    assign adv        = !valid_out_q || ready_in;
    assign ready_out  = adv && (state_q != S_FLUSH) && !reset;
    assign accept     = valid_in && ready_out;
    assign start      = accept && startofpacket_in;
    assign acc_run    = accept && !startofpacket_in && (state_q == S_FILL || state_q == S_RUN);
    assign flush_step = adv && (state_q == S_FLUSH);
    assign push       = start || acc_run || flush_step;
    assign emit       = (acc_run && (in_idx_q >= IDX_DLY)) || flush_step;
    assign push_pix   = flush_step ? '0 : data_in;
    assign push_col   = start ? '0 : in_col_q;

    assign cur_idx    = start ? '0 : in_idx_q;
    assign len_err_d  = accept && (state_q != S_IDLE || startofpacket_in)
                        && (endofpacket_in != (cur_idx == IDX_LAST));

    // Window shifts left; the new column is the pushed pixel under K-1 line-buffer reads
    always_comb begin
        for (int a = 0; a < K; a++) begin
            for (int b = 0; b < K - 1; b++) begin
                win_d[a][b] = win_q[a][b + 1];
            end
        end
        win_d[K-1][K-1] = push_pix;
        for (int j = 0; j < K - 1; j++) begin
            win_d[K-2-j][K-1] = lb_q[j][push_col];
        end
    end

    // Tap (a,b) maps to image position (cen_row+a-H, cen_col+b-H); out-of-frame taps read as zero
    always_comb begin
        row_ok = '0;
        col_ok = '0;
        for (int a = 0; a < K; a++) begin
            row_ok[a] = (int'(cen_row_q) + a - H >= 0) && (int'(cen_row_q) + a - H < IMG_H);
            col_ok[a] = (int'(cen_col_q) + a - H >= 0) && (int'(cen_col_q) + a - H < IMG_W);
        end
    end

    always_comb begin
        blur_pix = '0;
        sum_c    = '0;
        prod     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sum_c = '0;
            for (int a = 0; a < K; a++) begin
                for (int b = 0; b < K; b++) begin
                    if (row_ok[a] && col_ok[b]) begin
                        sum_c = sum_c + SW'(win_d[a][b][c*BPC +: BPC]);
                    end
                end
            end
            prod = PW'(sum_c) * PW'(RECIP) + PW'(32768);
            if (|prod[PW-1:16+BPC]) begin
                blur_pix[c*BPC +: BPC] = {BPC{1'b1}};
            end else begin
                blur_pix[c*BPC +: BPC] = prod[16 +: BPC];
            end
        end
    end

    assign data_d = blur_q ? blur_pix : win_d[H][H];

    always_ff @(posedge clk) begin
        if (push) begin
            lb_q[0][push_col] <= push_pix;
            for (int j = 1; j < K - 1; j++) begin
                lb_q[j][push_col] <= lb_q[j-1][push_col];
            end
            win_q <= win_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            blur_q      <= 1'b0;
            in_col_q    <= '0;
            in_idx_q    <= '0;
            cen_row_q   <= '0;
            cen_col_q   <= '0;
            cen_idx_q   <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            sop_out_q   <= 1'b0;
            eop_out_q   <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            len_err_q <= len_err_d;
            if (adv) begin
                valid_out_q <= emit;
                sop_out_q   <= emit && (cen_idx_q == '0);
                eop_out_q   <= emit && (cen_idx_q == IDX_LAST);
                if (emit) begin
                    data_out_q <= data_d;
                end
            end
            if (push) begin
                in_col_q <= (push_col == COL_LAST) ? '0 : push_col + 1'b1;
            end
            // A SOP in any accepting state restarts the frame; outputs still owed are abandoned
            if (start) begin
                state_q   <= S_FILL;
                blur_q    <= blur_en;
                in_idx_q  <= IW'(1);
                cen_row_q <= '0;
                cen_col_q <= '0;
                cen_idx_q <= '0;
            end else begin
                if (acc_run) begin
                    in_idx_q <= in_idx_q + 1'b1;
                    if (in_idx_q == IDX_LAST) begin
                        state_q <= S_FLUSH;
                    end else if (in_idx_q == IDX_DLY) begin
                        state_q <= S_RUN;
                    end
                end
                if (flush_step && (cen_idx_q == IDX_LAST)) begin
                    state_q <= S_IDLE;
                end
                if (emit) begin
                    cen_idx_q <= cen_idx_q + 1'b1;
                    if (cen_col_q == COL_LAST) begin
                        cen_col_q <= '0;
                        cen_row_q <= cen_row_q + 1'b1;
                    end else begin
                        cen_col_q <= cen_col_q + 1'b1;
                    end
                end
            end
        end
    end

    assign data_out          = data_out_q;
    assign valid_out         = valid_out_q;
    assign startofpacket_out = sop_out_q;
    assign endofpacket_out   = eop_out_q;
    assign len_err           = len_err_q;

endmodule

// File: tb/tb_dm_box_blur_stream.sv
// tb/tb_dm_box_blur_stream.sv - directed bench for dm_box_blur_stream (8x6 frames, K=3 and K=5)
`timescale 1ns/1ps
module tb_dm_box_blur_stream;
    localparam int W  = 8;
    localparam int HH = 6;
    localparam int N  = W * HH;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] data_in = '0;
    logic        vin = 1'b0, sop_in = 1'b0, eop_in = 1'b0, blur_en = 1'b0, ready_in = 1'b1;
    int          sel = 0;
    bit          gaps = 0, stall = 0;

    logic [11:0] d3, d5;
    logic        v3, r3, s3, e3, le3, v5, r5, s5, e5, le5;

    int n_checks = 0, n_fail = 0;
    logic [11:0] frm [N];
    logic [13:0] exp3 [$];
    logic [13:0] exp5 [$];
    logic [13:0] rx3 [1024];
    logic [13:0] rx5 [1024];
    int rxn3 = 0, rxn5 = 0, lecnt3 = 0;
    bit hold3 = 0, hold5 = 0;
    logic [13:0] prev3, prev5, e;

    always #5 clk = ~clk;

    dm_box_blur_stream #(.IMG_W(W), .IMG_H(HH), .BPC(4), .CHANNELS(3), .K(3)) u_k3 (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(vin && sel == 0), .ready_out(r3),
        .startofpacket_in(sop_in), .endofpacket_in(eop_in), .blur_en(blur_en),
        .data_out(d3), .valid_out(v3), .ready_in(ready_in),
        .startofpacket_out(s3), .endofpacket_out(e3), .len_err(le3));

    dm_box_blur_stream #(.IMG_W(W), .IMG_H(HH), .BPC(4), .CHANNELS(3), .K(5)) u_k5 (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(vin && sel == 1), .ready_out(r5),
        .startofpacket_in(sop_in), .endofpacket_in(eop_in), .blur_en(blur_en),
        .data_out(d5), .valid_out(v5), .ready_in(ready_in),
        .startofpacket_out(s5), .endofpacket_out(e5), .len_err(le5));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Reference: plain 2-D mean over the in-frame neighbourhood, divisor always kk*kk
    function automatic logic [13:0] model(input int kk, input logic be, input int idx);
        int r, c, h, recip, sum, m, rr, cc;
        logic [11:0] res;
        logic [11:0] px;
        r = idx / W;
        c = idx % W;
        h = kk / 2;
        recip = (2 * 65536 + kk * kk) / (2 * kk * kk);
        res = frm[idx];
        if (be) begin
            for (int ch = 0; ch < 3; ch++) begin
                sum = 0;
                for (int dr = -h; dr <= h; dr++) begin
                    for (int dc = -h; dc <= h; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (rr >= 0 && rr < HH && cc >= 0 && cc < W) begin
                            px = frm[rr * W + cc];
                            sum += int'(px[ch*4 +: 4]);
                        end
                    end
                end
                m = (sum * recip + 32768) >> 16;
                if (m > 15) m = 15;
                res[ch*4 +: 4] = m[3:0];
            end
        end
        return {idx == 0, idx == N - 1, res};
    endfunction

    task automatic push_exp(input int which, input logic be, input int count);
        for (int i = 0; i < count; i++) begin
            if (which == 0) exp3.push_back(model(3, be, i));
            else            exp5.push_back(model(5, be, i));
        end
    endtask

    task automatic send_beat(input logic [11:0] d, input logic s, input logic eo, input logic be);
        int to;
        logic acc;
        while (gaps && $urandom_range(0, 9) < 3) begin
            vin = 1'b0;
            @(posedge clk); #1;
        end
        data_in = d; sop_in = s; eop_in = eo; blur_en = be; vin = 1'b1;
        to = 0;
        while (1) begin
            @(negedge clk);
            acc = (sel == 0) ? r3 : r5;
            @(posedge clk);
            if (acc || to >= 1000) break;
            to++;
        end
        check("accept wait bounded", (to < 1000), 1);
        #1;
        vin = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
    endtask

    task automatic send_frame(input int nbeats, input logic be);
        for (int i = 0; i < nbeats; i++) send_beat(frm[i], i == 0, i == N - 1, be);
    endtask

    task automatic wait_drain(input int which);
        int t;
        t = 0;
        while (((which == 0) ? (exp3.size() != 0 || v3) : (exp5.size() != 0 || v5)) && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain bounded", (t < 3000), 1);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            ready_in = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            hold3 = 0;
            hold5 = 0;
        end else begin
            if (hold3) check("k3 stable while stalled", {v3, s3, e3, d3}, {1'b1, prev3});
            if (v3 && ready_in) begin
                check("k3 expected beat available", (exp3.size() > 0), 1);
                if (exp3.size() > 0) begin
                    e = exp3.pop_front();
                    check("k3 output beat", {s3, e3, d3}, e);
                end
                if (rxn3 < 1024) rx3[rxn3] = {s3, e3, d3};
                rxn3++;
            end
            hold3 = v3 && !ready_in;
            prev3 = {s3, e3, d3};
            if (le3) lecnt3++;
            if (hold5) check("k5 stable while stalled", {v5, s5, e5, d5}, {1'b1, prev5});
            if (v5 && ready_in) begin
                check("k5 expected beat available", (exp5.size() > 0), 1);
                if (exp5.size() > 0) begin
                    e = exp5.pop_front();
                    check("k5 output beat", {s5, e5, d5}, e);
                end
                if (rxn5 < 1024) rx5[rxn5] = {s5, e5, d5};
                rxn5++;
            end
            hold5 = v5 && !ready_in;
            prev5 = {s5, e5, d5};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b, l, cnt;
        repeat (3) @(posedge clk);
        #1;
        check("reset valid_out", v3, 0);
        check("reset ready_out", r3, 0);
        check("reset data_out", d3, 0);
        check("reset sop/eop/len_err", {s3, e3, le3}, 0);
        check("reset k5 valid_out", v5, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // constant white frame, blur on
        for (int i = 0; i < N; i++) frm[i] = 12'hFFF;
        b = rxn3; l = lecnt3;
        push_exp(0, 1, N);
        send_frame(N, 1);
        wait_drain(0);
        check("t1 output count", rxn3 - b, 48);
        check("t1 corner (0,0)", rx3[b], {2'b10, 12'h777});
        check("t1 top edge", rx3[b + 3], {2'b00, 12'hAAA});
        check("t1 left edge", rx3[b + 8], {2'b00, 12'hAAA});
        check("t1 interior", rx3[b + 9], {2'b00, 12'hFFF});
        check("t1 last pixel", rx3[b + 47], {2'b01, 12'h777});
        check("t1 no len_err", lecnt3 - l, 0);

        // bypass: pixel-for-pixel, first output one clock after accept #10
        for (int i = 0; i < N; i++) frm[i] = 12'(i * 149 + 7);
        b = rxn3;
        push_exp(0, 0, N);
        for (int i = 0; i < N; i++) begin
            send_beat(frm[i], i == 0, i == N - 1, 1'b0);
            if (i == 8) check("t2 no output before accept 10", v3, 0);
            if (i == 9) begin
                check("t2 valid after accept 10", v3, 1);
                check("t2 first output data", d3, 12'h007);
            end
        end
        wait_drain(0);
        check("t2 output count", rxn3 - b, 48);
        check("t2 pixel 17 passthrough", rx3[b + 17], {2'b00, 12'h9EC});

        // K=5 impulse
        sel = 1;
        for (int i = 0; i < N; i++) frm[i] = 12'h000;
        frm[27] = 12'hF00;
        b = rxn5;
        push_exp(1, 1, N);
        send_frame(N, 1);
        wait_drain(1);
        cnt = 0;
        for (int k = 0; k < 48; k++) if (rx5[b + k][11:0] == 12'h100) cnt++;
        check("t3 output count", rxn5 - b, 48);
        check("t3 impulse spread count", cnt, 25);
        check("t3 centre (3,3)", rx5[b + 27], {2'b00, 12'h100});
        check("t3 corner (0,0)", rx5[b], {2'b10, 12'h000});
        sel = 0;

        // random gaps and backpressure, two back-to-back frames
        stall = 1; gaps = 1;
        b = rxn3;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < N; i++) frm[i] = 12'($urandom);
            push_exp(0, f == 0, N);
            send_frame(N, f == 0);
        end
        wait_drain(0);
        stall = 0; gaps = 0;
        @(posedge clk); #1;
        check("t4 output count", rxn3 - b, 96);

        // SOP re-issued at idx 20 aborts the frame
        for (int i = 0; i < N; i++) frm[i] = 12'($urandom);
        b = rxn3;
        push_exp(0, 1, 11);
        for (int i = 0; i < 20; i++) send_beat(frm[i], i == 0, 1'b0, 1'b1);
        for (int i = 0; i < N; i++) frm[i] = 12'($urandom);
        push_exp(0, 0, N);
        send_frame(N, 0);
        wait_drain(0);
        cnt = 0;
        for (int k = 0; k < 59; k++) if (rx3[b + k][12]) cnt++;
        check("t5 output count", rxn3 - b, 59);
        check("t5 single EOP", cnt, 1);
        check("t5 restart SOP", rx3[b + 11][13], 1);

        // early endofpacket_in at idx 40
        for (int i = 0; i < N; i++) frm[i] = 12'($urandom);
        b = rxn3; l = lecnt3;
        push_exp(0, 1, N);
        for (int i = 0; i < N; i++) begin
            send_beat(frm[i], i == 0, (i == 40) || (i == 47), 1'b1);
            if (i == 40) check("t6 len_err at idx 40", le3, 1);
            if (i == 41) check("t6 len_err one cycle", le3, 0);
        end
        wait_drain(0);
        check("t6 len_err pulses", lecnt3 - l, 1);
        check("t6 output count", rxn3 - b, 48);
        check("t6 EOP on output 48", rx3[b + 47][12], 1);

        // reset at idx 30, then a fresh frame
        for (int i = 0; i < N; i++) frm[i] = 12'($urandom);
        b = rxn3;
        push_exp(0, 1, 21);
        for (int i = 0; i < 30; i++) send_beat(frm[i], i == 0, 1'b0, 1'b1);
        wait_drain(0);
        check("t6 outputs before reset", rxn3 - b, 21);
        reset = 1'b1;
        @(posedge clk); #1;
        check("t6 reset valid_out", v3, 0);
        check("t6 reset ready_out", r3, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < N; i++) frm[i] = 12'($urandom);
        b = rxn3;
        push_exp(0, 1, N);
        send_frame(N, 1);
        wait_drain(0);
        check("t6 frame after reset count", rxn3 - b, 48);
        check("expected queues empty", exp3.size() + exp5.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
